// File: rtl/ffn_sched_pkg.sv
// rtl/ffn_sched_pkg.sv - shared constants and state encoding for ffn_share_scheduler
package ffn_sched_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_IDIM    = 512;
    localparam int DEF_WIDTH   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/ffn_share_scheduler_rr_arbiter.sv
// rtl/ffn_share_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [GW-1:0] grant_idx,
    output logic          any_req
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [GW-1:0]  off;
    logic [GW:0]    sum;

    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        off     = '0;
        any_req = |req;
        // walk downward so the lowest offset from ptr is the one left standing
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = GW'(k);
            end
        end
        sum       = {1'b0, ptr} + {1'b0, off};
        grant_idx = (sum >= (GW + 1)'(N)) ? GW'(sum - (GW + 1)'(N)) : sum[GW-1:0];
        grant_oh  = any_req ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/ffn_share_scheduler.sv
// rtl/ffn_share_scheduler.sv - round-robin sharing of one FFN engine; watchdog under FFN_SCHED_TIMEOUT_EN
module ffn_share_scheduler
    import ffn_sched_pkg::*;
#(
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int IDIM           = DEF_IDIM,
    parameter  int WIDTH          = DEF_WIDTH,
    parameter  int TIMEOUT_CYCLES = 4096,
    localparam int DW             = IDIM * WIDTH,
    localparam int GW             = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [DW-1:0]           resp_data,
    output logic                    resp_err,
    output logic                    eng_start,
    output logic [DW-1:0]           eng_data,
    output logic [GW-1:0]           eng_bank_sel,
    input  logic                    eng_done,
    input  logic [DW-1:0]           eng_result,
    output logic                    busy
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ffn_share_scheduler: NUM_REQ and TIMEOUT_CYCLES must be at least 2");
    end

    sched_state_e          state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [DW-1:0]         eng_data_q, eng_data_d;
    logic [DW-1:0]         resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0]    arb_oh;
    logic [GW-1:0]         arb_idx;
    logic                  arb_any;

`ifdef FFN_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  resp_err_q, resp_err_d;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        eng_data_d  = eng_data_q;
        resp_data_d = resp_data_q;
        req_ready   = '0;
`ifdef FFN_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
        resp_err_d  = resp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = arb_oh;
                if (arb_any) begin
                    grant_d = arb_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_idx == GW'(i)) begin
                            eng_data_d = req_data[i*DW +: DW];
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef FFN_SCHED_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    resp_data_d = eng_result;
`ifdef FFN_SCHED_TIMEOUT_EN
                    resp_err_d  = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef FFN_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (resp_ready[grant_q]) begin
                    ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            eng_data_q  <= '0;
            resp_data_q <= '0;
`ifdef FFN_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            resp_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            eng_data_q  <= eng_data_d;
            resp_data_q <= resp_data_d;
`ifdef FFN_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            resp_err_q  <= resp_err_d;
`endif
        end
    end

    assign eng_start    = (state_q == S_ISSUE);
    assign eng_data     = eng_data_q;
    assign eng_bank_sel = grant_q;
    assign resp_data    = resp_data_q;
    assign resp_valid   = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign busy         = (state_q != S_IDLE);
`ifdef FFN_SCHED_TIMEOUT_EN
    assign resp_err     = resp_err_q;
`else
    assign resp_err     = 1'b0;
`endif

endmodule
